// File: rtl/lcd_char_write_ctrl.sv
// HD44780-style character LCD writer: power-up wait, init commands, then a
// continuously refreshed 16+4 character frame fetched from a 1-cycle-latency ROM.
module lcd_char_write_ctrl #(
    parameter int T_EN         = 4,
    parameter int PWR_WAIT     = 16,
    parameter int CLR_WAIT     = 32,
    parameter int REFRESH_WAIT = 64
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_rom_data,
    output logic [4:0] o_rom_addr,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw,
    output logic       o_lcd_en,
    output logic [7:0] o_lcd_data,
    output logic       o_init_done,
    output logic       o_frame_done
);

    typedef enum logic [3:0] {
        S_PWR, S_INIT, S_CLRW, S_ADDR1, S_FETCH, S_CHAR, S_ADDR2, S_FDONE, S_RWAIT
    } state_t;

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [15:0] r_wcnt;
    logic [1:0]  r_step;
    logic [4:0]  r_index;
    logic [4:0]  r_rom_addr;
    logic        r_rs;
    logic        r_en;
    logic [7:0]  r_data;
    logic        r_init_done;
    logic        r_frame_done;

    logic [15:0] w_wcnt_inc;
    logic        w_wr_last;
    logic        w_en_next;
    logic [7:0]  w_next_cmd;

    // Write phase counter: setup, EN-high and hold each last T_EN cycles.
    assign w_wcnt_inc = r_wcnt + 16'd1;
    assign w_wr_last  = (r_wcnt == 16'(3 * T_EN - 1));
    assign w_en_next  = (w_wcnt_inc >= 16'(T_EN)) && (w_wcnt_inc < 16'(2 * T_EN));

    always_comb begin
        w_next_cmd = 8'h01;
        case (r_step)
            2'd0:    w_next_cmd = 8'h0C;
            2'd1:    w_next_cmd = 8'h06;
            default: w_next_cmd = 8'h01;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_PWR;
            r_cnt        <= 16'd0;
            r_wcnt       <= 16'd0;
            r_step       <= 2'd0;
            r_index      <= 5'd0;
            r_rom_addr   <= 5'd0;
            r_rs         <= 1'b0;
            r_en         <= 1'b0;
            r_data       <= 8'h00;
            r_init_done  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_PWR: begin
                    if (r_cnt == 16'(PWR_WAIT - 1)) begin
                        r_rs    <= 1'b0;
                        r_data  <= 8'h38;
                        r_wcnt  <= 16'd0;
                        r_en    <= 1'b0;
                        r_step  <= 2'd0;
                        r_state <= S_INIT;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_INIT: begin
                    if (!w_wr_last) begin
                        r_wcnt <= w_wcnt_inc;
                        r_en   <= w_en_next;
                    end else if (r_step == 2'd3) begin
                        r_cnt   <= 16'd0;
                        r_state <= S_CLRW;
                    end else begin
                        r_step <= r_step + 2'd1;
                        r_data <= w_next_cmd;
                        r_wcnt <= 16'd0;
                        r_en   <= 1'b0;
                    end
                end
                S_CLRW: begin
                    if (r_cnt == 16'(CLR_WAIT - 1)) begin
                        r_init_done <= 1'b1;
                        r_rs        <= 1'b0;
                        r_data      <= 8'h80;
                        r_wcnt      <= 16'd0;
                        r_en        <= 1'b0;
                        r_state     <= S_ADDR1;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_ADDR1: begin
                    if (!w_wr_last) begin
                        r_wcnt <= w_wcnt_inc;
                        r_en   <= w_en_next;
                    end else begin
                        r_index    <= 5'd0;
                        r_rom_addr <= 5'd0;
                        r_cnt      <= 16'd0;
                        r_state    <= S_FETCH;
                    end
                end
                // Cycle 0: address is on the bus; cycle 1: ROM output is valid.
                S_FETCH: begin
                    if (r_cnt == 16'd1) begin
                        r_rs    <= 1'b1;
                        r_data  <= i_rom_data;
                        r_wcnt  <= 16'd0;
                        r_en    <= 1'b0;
                        r_state <= S_CHAR;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_CHAR: begin
                    if (!w_wr_last) begin
                        r_wcnt <= w_wcnt_inc;
                        r_en   <= w_en_next;
                    end else if (r_index == 5'd15) begin
                        r_rs    <= 1'b0;
                        r_data  <= 8'hC0;
                        r_wcnt  <= 16'd0;
                        r_en    <= 1'b0;
                        r_state <= S_ADDR2;
                    end else if (r_index == 5'd19) begin
                        r_frame_done <= 1'b1;
                        r_state      <= S_FDONE;
                    end else begin
                        r_index    <= r_index + 5'd1;
                        r_rom_addr <= r_index + 5'd1;
                        r_cnt      <= 16'd0;
                        r_state    <= S_FETCH;
                    end
                end
                S_ADDR2: begin
                    if (!w_wr_last) begin
                        r_wcnt <= w_wcnt_inc;
                        r_en   <= w_en_next;
                    end else begin
                        r_index    <= 5'd16;
                        r_rom_addr <= 5'd16;
                        r_cnt      <= 16'd0;
                        r_state    <= S_FETCH;
                    end
                end
                S_FDONE: begin
                    if (REFRESH_WAIT == 0) begin
                        r_rs    <= 1'b0;
                        r_data  <= 8'h80;
                        r_wcnt  <= 16'd0;
                        r_en    <= 1'b0;
                        r_state <= S_ADDR1;
                    end else begin
                        r_cnt   <= 16'd0;
                        r_state <= S_RWAIT;
                    end
                end
                S_RWAIT: begin
                    if (r_cnt == 16'(REFRESH_WAIT - 1)) begin
                        r_rs    <= 1'b0;
                        r_data  <= 8'h80;
                        r_wcnt  <= 16'd0;
                        r_en    <= 1'b0;
                        r_state <= S_ADDR1;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: r_state <= S_PWR;
            endcase
        end
    end

    assign o_rom_addr   = r_rom_addr;
    assign o_lcd_rs     = r_rs;
    assign o_lcd_rw     = 1'b0;
    assign o_lcd_en     = r_en;
    assign o_lcd_data   = r_data;
    assign o_init_done  = r_init_done;
    assign o_frame_done = r_frame_done;

endmodule
